// File: rtl/pmips_l1_core.sv
// pmips_l1_core: five-stage 16-bit PMIPS pipeline (IF/ID/EX/MEM/WB) with forwarding and load-use interlock.
// Optional PMIPS_BPRED_EN enables a global 3-bit saturating branch predictor; otherwise branches predict not-taken.
module pmips_l1_core (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] imemaddr,
  input  logic [15:0] imemrdata,
  output logic [15:0] dmemaddr,
  output logic [15:0] dmemwdata,
  output logic        dmemwrite,
  output logic        dmemread,
  input  logic [15:0] dmemrdata,
  output logic [15:0] aluresult,
  output logic        debug,
  output logic        debug8,
  output logic        stall,
  output logic [15:0] debug2,
  output logic [15:0] debug3,
  output logic [15:0] debug4,
  output logic        debug5,
  output logic [15:0] debug6,
  output logic [15:0] debug7,
  output logic [2:0]  Predict,
  output logic [3:0]  code,
  output logic [15:0] RegDst,
  output logic [2:0]  regg,
  output logic [15:0] branch
);
  typedef struct packed {
    logic [15:0] instr, pc2, a, b, imm, target;
    logic [2:0]  dest;
    logic [3:0]  alu;
    logic        regwrite, memread, memwrite, alusrc, isbranch, isbne, pred;
  } idex_t;
  typedef struct packed {
    logic [15:0] instr, alu, sdata;
    logic [2:0]  dest;
    logic        regwrite, memread, memwrite;
  } exmem_t;
  typedef struct packed {
    logic [15:0] alu, ldata;
    logic [2:0]  dest;
    logic        regwrite, memread;
  } memwb_t;

  logic [15:0]      pc_q, pc_d, ifid_instr_q, ifid_instr_d, ifid_pc2_q, ifid_pc2_d;
  idex_t            idex_q, idex_d, dec;
  exmem_t           exmem_q, exmem_d;
  memwb_t           memwb_q, memwb_d;
  logic [7:0][15:0] regs_q, regs_d;

  logic [2:0]  op_id, rs_id, rt_id, rs_ex, rt_ex;
  logic [15:0] imm_id, br_target, j_target, rs_val, rt_val, wb_data;
  logic [15:0] fwd_a, fwd_b, opb, alu_out;
  logic        wb_we, is_jump_id, is_branch_id, pred_id;
  logic        taken, mispredict, load_use, lu_stall, redirect, flush;

`ifdef PMIPS_BPRED_EN
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (idex_q.isbranch) begin
      if (taken && cnt_q != 3'd7)       cnt_d = cnt_q + 3'd1;
      else if (!taken && cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= 3'b011;
    else       cnt_q <= cnt_d;
  end

  assign Predict = cnt_q;
`else
  assign Predict = 3'b000;
`endif

  always_comb begin
    wb_data = memwb_q.memread ? memwb_q.ldata : memwb_q.alu;
    wb_we   = memwb_q.regwrite && (memwb_q.dest != 3'd0);
    regs_d  = regs_q;
    if (wb_we) regs_d[memwb_q.dest] = wb_data;
  end

  // ID: decode, write-through register read, jump/branch targets and prediction
  always_comb begin
    op_id        = ifid_instr_q[15:13];
    rs_id        = ifid_instr_q[12:10];
    rt_id        = ifid_instr_q[9:7];
    imm_id       = {{9{ifid_instr_q[6]}}, ifid_instr_q[6:0]};
    br_target    = ifid_pc2_q + {imm_id[14:0], 1'b0};
    j_target     = {ifid_pc2_q[15:14], ifid_instr_q[12:0], 1'b0};
    rs_val       = (wb_we && memwb_q.dest == rs_id) ? wb_data : regs_q[rs_id];
    rt_val       = (wb_we && memwb_q.dest == rt_id) ? wb_data : regs_q[rt_id];
    is_jump_id   = (op_id == 3'd7);
    is_branch_id = (op_id == 3'd1) || (op_id == 3'd2);
`ifdef PMIPS_BPRED_EN
    pred_id      = is_branch_id && cnt_q[2];
`else
    pred_id      = 1'b0;
`endif
    dec        = '0;
    dec.instr  = ifid_instr_q;
    dec.pc2    = ifid_pc2_q;
    dec.a      = rs_val;
    dec.b      = rt_val;
    dec.imm    = imm_id;
    dec.target = br_target;
    dec.pred   = pred_id;
    case (op_id)
      3'd0: begin
        dec.regwrite = (ifid_instr_q != 16'h0000);
        dec.dest     = ifid_instr_q[6:4];
        dec.alu      = (ifid_instr_q[3:0] <= 4'd4) ? ifid_instr_q[3:0] : 4'd0;
      end
      3'd1, 3'd2: begin dec.isbranch = 1'b1; dec.isbne = op_id[1]; dec.alu = 4'd1; end
      3'd3: begin dec.regwrite = 1'b1; dec.dest = rt_id; dec.alusrc = 1'b1; end
      3'd4: begin dec.regwrite = 1'b1; dec.dest = rt_id; dec.alusrc = 1'b1; dec.memread = 1'b1; end
      3'd5: begin dec.memwrite = 1'b1; dec.alusrc = 1'b1; end
      3'd6: begin dec.regwrite = 1'b1; dec.dest = rt_id; dec.alusrc = 1'b1; dec.alu = 4'd4; end
      default: ;
    endcase
  end

  // EX: forwarding (EX/MEM first), ALU, branch resolution
  always_comb begin
    rs_ex = idex_q.instr[12:10];
    rt_ex = idex_q.instr[9:7];
    fwd_a = idex_q.a;
    if (exmem_q.regwrite && exmem_q.dest != 3'd0 && exmem_q.dest == rs_ex) fwd_a = exmem_q.alu;
    else if (wb_we && memwb_q.dest == rs_ex)                                fwd_a = wb_data;
    fwd_b = idex_q.b;
    if (exmem_q.regwrite && exmem_q.dest != 3'd0 && exmem_q.dest == rt_ex) fwd_b = exmem_q.alu;
    else if (wb_we && memwb_q.dest == rt_ex)                                fwd_b = wb_data;
    opb = idex_q.alusrc ? idex_q.imm : fwd_b;
    case (idex_q.alu)
      4'd1:    alu_out = fwd_a - opb;
      4'd2:    alu_out = fwd_a & opb;
      4'd3:    alu_out = fwd_a | opb;
      4'd4:    alu_out = {15'd0, $signed(fwd_a) < $signed(opb)};
      default: alu_out = fwd_a + opb;
    endcase
    taken      = idex_q.isbranch && (idex_q.isbne ? (fwd_a != fwd_b) : (fwd_a == fwd_b));
    mispredict = idex_q.isbranch && (taken != idex_q.pred);
  end

  // Redirect priority: EX mispredict, then load-use hold, then ID jump/predicted-taken
  always_comb begin
    load_use     = idex_q.memread && (idex_q.dest == rs_id || idex_q.dest == rt_id);
    pc_d         = pc_q + 16'd2;
    ifid_instr_d = imemrdata;
    ifid_pc2_d   = pc_q + 16'd2;
    idex_d       = dec;
    redirect     = 1'b0;
    flush        = 1'b0;
    lu_stall     = 1'b0;
    if (mispredict) begin
      pc_d         = taken ? idex_q.target : idex_q.pc2;
      ifid_instr_d = 16'h0000;
      idex_d       = '0;
      redirect     = 1'b1;
      flush        = 1'b1;
    end else if (load_use) begin
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc2_d   = ifid_pc2_q;
      idex_d       = '0;
      lu_stall     = 1'b1;
    end else if (is_jump_id || pred_id) begin
      pc_d         = is_jump_id ? j_target : br_target;
      ifid_instr_d = 16'h0000;
      redirect     = 1'b1;
      flush        = 1'b1;
    end
    exmem_d.instr    = idex_q.instr;
    exmem_d.alu      = alu_out;
    exmem_d.sdata    = fwd_b;
    exmem_d.dest     = idex_q.dest;
    exmem_d.regwrite = idex_q.regwrite;
    exmem_d.memread  = idex_q.memread;
    exmem_d.memwrite = idex_q.memwrite;
    memwb_d.alu      = exmem_q.alu;
    memwb_d.ldata    = exmem_q.memread ? dmemrdata : 16'h0000;
    memwb_d.dest     = exmem_q.dest;
    memwb_d.regwrite = exmem_q.regwrite;
    memwb_d.memread  = exmem_q.memread;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q         <= 16'h0000;
      ifid_instr_q <= 16'h0000;
      ifid_pc2_q   <= 16'h0000;
      idex_q       <= '0;
      exmem_q      <= '0;
      memwb_q      <= '0;
      regs_q       <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc2_q   <= ifid_pc2_d;
      idex_q       <= idex_d;
      exmem_q      <= exmem_d;
      memwb_q      <= memwb_d;
      regs_q       <= regs_d;
    end
  end

  assign imemaddr  = pc_q;
  assign dmemaddr  = exmem_q.alu;
  assign dmemwdata = exmem_q.sdata;
  assign dmemwrite = exmem_q.memwrite;
  assign dmemread  = exmem_q.memread;
  assign aluresult = alu_out;
  assign debug     = redirect;
  assign debug8    = lu_stall;
  assign stall     = flush;
  assign debug2    = ifid_instr_q;
  assign debug3    = idex_q.instr;
  assign debug4    = exmem_q.instr;
  assign debug5    = memwb_q.regwrite;
  assign debug6    = memwb_q.ldata;
  assign debug7    = exmem_q.alu;
  assign code      = idex_q.alu;
  assign RegDst    = wb_data;
  assign regg      = memwb_q.dest;
  assign branch    = br_target;
endmodule

// File: tb/tb_pmips_l1_core.sv
// Directed self-checking bench for pmips_l1_core; expectations follow PMIPS_BPRED_EN when it is defined.
module tb_pmips_l1_core;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] imemaddr, imemrdata, dmemaddr, dmemwdata, dmemrdata, aluresult;
  logic        dmemwrite, dmemread, debug, debug8, stall, debug5;
  logic [15:0] debug2, debug3, debug4, debug6, debug7, RegDst, branch;
  logic [2:0]  Predict, regg;
  logic [3:0]  code;

  logic [15:0] imem [0:255];
  logic [15:0] dmem [0:255];
  int cmp_count = 0;
  int err_count = 0;

`ifdef PMIPS_BPRED_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif
  localparam logic [2:0] PRED_RST = BP ? 3'd3 : 3'd0;

  pmips_l1_core dut (
    .clock(clock), .reset(reset), .imemaddr(imemaddr), .imemrdata(imemrdata),
    .dmemaddr(dmemaddr), .dmemwdata(dmemwdata), .dmemwrite(dmemwrite), .dmemread(dmemread),
    .dmemrdata(dmemrdata), .aluresult(aluresult), .debug(debug), .debug8(debug8), .stall(stall),
    .debug2(debug2), .debug3(debug3), .debug4(debug4), .debug5(debug5), .debug6(debug6),
    .debug7(debug7), .Predict(Predict), .code(code), .RegDst(RegDst), .regg(regg), .branch(branch)
  );

  always #5 clock = ~clock;
  assign imemrdata = imem[imemaddr[8:1]];
  assign dmemrdata = dmem[dmemaddr[8:1]];
  always @(posedge clock) if (dmemwrite) dmem[dmemaddr[8:1]] <= dmemwdata;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  task automatic test_reset();
    hold_reset();
    cmp_count++; if (imemaddr !== 16'h0) begin err_count++; $display("FAIL rst_pc got %h want 0000", imemaddr); end
    cmp_count++; if (dmemwrite !== 1'b0) begin err_count++; $display("FAIL rst_dmemwrite got %b want 0", dmemwrite); end
    cmp_count++; if (dmemread !== 1'b0) begin err_count++; $display("FAIL rst_dmemread got %b want 0", dmemread); end
    cmp_count++; if ({debug2, debug3, debug4} !== 48'h0) begin err_count++; $display("FAIL rst_pipe got %h %h %h want 0", debug2, debug3, debug4); end
    cmp_count++; if (debug5 !== 1'b0) begin err_count++; $display("FAIL rst_regwrite got %b want 0", debug5); end
    cmp_count++; if (Predict !== PRED_RST) begin err_count++; $display("FAIL rst_predict got %0d want %0d", Predict, PRED_RST); end
    cmp_count++; if ({debug, stall, debug8} !== 3'b000) begin err_count++; $display("FAIL rst_ctrl got %b%b%b want 000", debug, stall, debug8); end
    cmp_count++; if (RegDst !== 16'h0) begin err_count++; $display("FAIL rst_regdst got %h want 0000", RegDst); end
  endtask

  task automatic test_forwarding();
    hold_reset();
    imem[0] = 16'h6085; imem[1] = 16'h6103; imem[2] = 16'h0530;
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 3) begin
        cmp_count++; if (imemaddr !== 16'h0006) begin err_count++; $display("FAIL fw_pc got %h want 0006", imemaddr); end
      end
      if (c == 4) begin
        cmp_count++; if (regg !== 3'd1 || RegDst !== 16'd5 || debug5 !== 1'b1) begin err_count++; $display("FAIL fw_wb1 got r%0d=%0d we=%b want r1=5 we=1", regg, RegDst, debug5); end
        cmp_count++; if (aluresult !== 16'd8 || code !== 4'd0) begin err_count++; $display("FAIL fw_alu got %0d code %0d want 8 code 0", aluresult, code); end
      end
      if (c == 5) begin
        cmp_count++; if (regg !== 3'd2 || RegDst !== 16'd3) begin err_count++; $display("FAIL fw_wb2 got r%0d=%0d want r2=3", regg, RegDst); end
      end
      if (c == 6) begin
        cmp_count++; if (regg !== 3'd3 || RegDst !== 16'd8) begin err_count++; $display("FAIL fw_wb3 got r%0d=%0d want r3=8", regg, RegDst); end
      end
      cmp_count++; if (debug8 !== 1'b0) begin err_count++; $display("FAIL fw_nostall cycle %0d got %b want 0", c, debug8); end
    end
  endtask

  task automatic load_use_prog();
    imem[0] = 16'h6188; imem[1] = 16'hA180; imem[2] = 16'h8200; imem[3] = 16'h1250;
  endtask

  task automatic test_load_use();
    hold_reset();
    load_use_prog();
    reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 4) begin
        cmp_count++; if (dmemwrite !== 1'b1 || dmemaddr !== 16'h0 || dmemwdata !== 16'd8) begin err_count++; $display("FAIL lu_store got we=%b a=%h d=%h want we=1 a=0000 d=0008", dmemwrite, dmemaddr, dmemwdata); end
        cmp_count++; if (debug8 !== 1'b1 || imemaddr !== 16'h0008) begin err_count++; $display("FAIL lu_stall got st=%b pc=%h want st=1 pc=0008", debug8, imemaddr); end
      end
      if (c == 5) begin
        cmp_count++; if (debug8 !== 1'b0 || imemaddr !== 16'h0008) begin err_count++; $display("FAIL lu_release got st=%b pc=%h want st=0 pc=0008", debug8, imemaddr); end
        cmp_count++; if (debug3 !== 16'h0 || debug2 !== 16'h1250 || dmemread !== 1'b1) begin err_count++; $display("FAIL lu_bubble got idex=%h ifid=%h rd=%b want 0000 1250 1", debug3, debug2, dmemread); end
      end
      if (c == 6) begin
        cmp_count++; if (regg !== 3'd4 || RegDst !== 16'd8 || debug6 !== 16'd8) begin err_count++; $display("FAIL lu_load got r%0d=%0d ld=%0d want r4=8 ld=8", regg, RegDst, debug6); end
        cmp_count++; if (aluresult !== 16'd16) begin err_count++; $display("FAIL lu_fwd got %0d want 16", aluresult); end
      end
      if (c == 8) begin
        cmp_count++; if (regg !== 3'd5 || RegDst !== 16'd16) begin err_count++; $display("FAIL lu_wb got r%0d=%0d want r5=16", regg, RegDst); end
      end
    end
  endtask

  task automatic test_branch_taken();
    hold_reset();
    imem[0] = 16'h2002; imem[1] = 16'h6081; imem[2] = 16'h6102; imem[3] = 16'h6183;
    reset = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) begin
        cmp_count++; if (branch !== 16'h0006 || debug !== 1'b0) begin err_count++; $display("FAIL bt_target got %h redir=%b want 0006 0", branch, debug); end
      end
      if (c == 2) begin
        cmp_count++; if (debug !== 1'b1 || stall !== 1'b1 || imemaddr !== 16'h0004) begin err_count++; $display("FAIL bt_mispredict got %b%b pc=%h want 11 pc=0004", debug, stall, imemaddr); end
      end
      if (c == 3) begin
        cmp_count++; if (imemaddr !== 16'h0006 || debug2 !== 16'h0 || debug3 !== 16'h0) begin err_count++; $display("FAIL bt_flush got pc=%h ifid=%h idex=%h want 0006 0000 0000", imemaddr, debug2, debug3); end
        cmp_count++; if (Predict !== (BP ? 3'd4 : 3'd0)) begin err_count++; $display("FAIL bt_predict got %0d want %0d", Predict, BP ? 4 : 0); end
      end
      if (c == 5 || c == 6) begin
        cmp_count++; if (debug5 !== 1'b0) begin err_count++; $display("FAIL bt_squash cycle %0d got %b want 0", c, debug5); end
      end
      if (c == 7) begin
        cmp_count++; if (regg !== 3'd3 || RegDst !== 16'd3) begin err_count++; $display("FAIL bt_wb got r%0d=%0d want r3=3", regg, RegDst); end
      end
    end
  endtask

  task automatic test_jump();
    hold_reset();
    imem[0] = 16'hE010; imem[1] = 16'h6081; imem[16] = 16'h6307;
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin
        cmp_count++; if (debug !== 1'b1 || stall !== 1'b1 || debug8 !== 1'b0) begin err_count++; $display("FAIL j_redir got %b%b%b want 110", debug, stall, debug8); end
      end
      if (c == 2) begin
        cmp_count++; if (imemaddr !== 16'h0020 || debug2 !== 16'h0) begin err_count++; $display("FAIL j_target got pc=%h ifid=%h want 0020 0000", imemaddr, debug2); end
      end
      if (c == 5) begin
        cmp_count++; if (debug5 !== 1'b0) begin err_count++; $display("FAIL j_squash got %b want 0", debug5); end
      end
      if (c == 6) begin
        cmp_count++; if (regg !== 3'd6 || RegDst !== 16'd7) begin err_count++; $display("FAIL j_wb got r%0d=%0d want r6=7", regg, RegDst); end
      end
    end
  endtask

  task automatic test_branch_loop();
    logic [12:0] exp_dbg;
    exp_dbg = BP ? 13'h1554 : 13'h0924;
    hold_reset();
    imem[0] = 16'h207F;
    reset = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      cmp_count++; if (debug !== exp_dbg[c]) begin err_count++; $display("FAIL loop_redir cycle %0d got %b want %b", c, debug, exp_dbg[c]); end
    end
    cmp_count++; if (Predict !== (BP ? 3'd7 : 3'd0)) begin err_count++; $display("FAIL loop_predict got %0d want %0d", Predict, BP ? 7 : 0); end
  endtask

  task automatic test_bne_mispredict();
    hold_reset();
    imem[0] = 16'h2000; imem[1] = 16'h4003; imem[2] = 16'h6089; imem[5] = 16'h6101; imem[6] = 16'h6101;
    reset = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 4) begin
        cmp_count++; if (branch !== 16'h000A || debug !== BP) begin err_count++; $display("FAIL bne_pred got tgt=%h redir=%b want 000a %b", branch, debug, BP); end
      end
      if (c == 5) begin
        cmp_count++; if (debug !== BP || stall !== BP || imemaddr !== (BP ? 16'h000A : 16'h0006)) begin err_count++; $display("FAIL bne_resolve got %b%b pc=%h want %b%b pc=%h", debug, stall, imemaddr, BP, BP, BP ? 16'h000A : 16'h0006); end
      end
      if (c == 6) begin
        cmp_count++; if (imemaddr !== (BP ? 16'h0004 : 16'h0008) || Predict !== (BP ? 3'd3 : 3'd0)) begin err_count++; $display("FAIL bne_recover got pc=%h pr=%0d want pc=%h pr=%0d", imemaddr, Predict, BP ? 16'h0004 : 16'h0008, BP ? 3 : 0); end
      end
      if (c == (BP ? 10 : 8)) begin
        cmp_count++; if (regg !== 3'd1 || RegDst !== 16'd9) begin err_count++; $display("FAIL bne_wb got r%0d=%0d want r1=9", regg, RegDst); end
      end
    end
  endtask

  task automatic test_reset_midop();
    hold_reset();
    load_use_prog();
    reset = 1'b0;
    repeat (4) tick();
    cmp_count++; if (dmemwrite !== 1'b1) begin err_count++; $display("FAIL mid_pre got %b want 1", dmemwrite); end
    #1 reset = 1'b1;
    #1;
    cmp_count++; if (imemaddr !== 16'h0 || dmemwrite !== 1'b0 || dmemread !== 1'b0) begin err_count++; $display("FAIL mid_clear got pc=%h we=%b rd=%b want 0000 0 0", imemaddr, dmemwrite, dmemread); end
    cmp_count++; if ({debug2, debug3, debug4} !== 48'h0 || debug5 !== 1'b0 || Predict !== PRED_RST) begin err_count++; $display("FAIL mid_pipe got %h %h %h we=%b pr=%0d", debug2, debug3, debug4, debug5, Predict); end
    @(negedge clock);
    reset = 1'b0;
    tick();
    cmp_count++; if (debug2 !== 16'h6188 || imemaddr !== 16'h0002) begin err_count++; $display("FAIL mid_resume got ifid=%h pc=%h want 6188 0002", debug2, imemaddr); end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_taken();
    test_jump();
    test_branch_loop();
    test_bne_mispredict();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end
endmodule
